// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for DIGITS common-anode 7-segment digits.
// One shared BCD decode path, a dead-time guard before every digit, leading-zero blanking,
// per-digit decimal points, and a frame-synchronous update handshake so the displayed value
// never changes mid-frame.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   val_in   packed BCD, digit i = val_in[4i+3:4i], digit 0 least significant
//   dp_in    decimal point request per digit (1 = on)
//   upd_req  1-cycle strobe: capture val_in/dp_in for display
//   upd_ack  1-cycle pulse: captured data became active
//   lz_en    1 = blank leading zeros (sampled live)
//   seg      active-low segments, bit0..6 = a..g, bit7 = dp
//   dig_n    active-low digit enables, at most one low
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DWELL  = 50000,
  parameter int unsigned GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   val_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  upd_req,
  output logic                  upd_ack,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_n
);

  localparam int unsigned CntMax = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StGuard, StShow} state_e;

  state_e                r_state, w_state_nxt;
  logic [IdxW-1:0]       r_idx, w_idx_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [4*DIGITS-1:0]   r_val, w_val_nxt;
  logic [DIGITS-1:0]     r_dp, w_dp_nxt;
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic                  r_pending;
  logic                  r_ack;
  logic [7:0]            r_seg, w_seg_nxt;
  logic [DIGITS-1:0]     r_dig_n, w_dig_n_nxt;

  logic                  w_boundary;
  logic                  w_commit;
  logic [DIGITS-1:0]     w_zero_above;
  logic [3:0]            w_digit;
  logic                  w_dp_bit;
  logic                  w_blank;

  // Active-low a..g pattern for BCD 0..9; codes 10..15 light nothing.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan sequencer: GUARD (all off) then SHOW for each digit in turn.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      StGuard: begin
        if (r_cnt == GuardLast) begin
          w_state_nxt = StShow;
          w_cnt_nxt   = '0;
        end
      end
      StShow: begin
        if (r_cnt == DwellLast) begin
          w_state_nxt = StGuard;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StGuard;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // The first GUARD cycle of digit 0 is the only point where the active value may change.
  assign w_boundary = (r_state == StGuard) && (r_idx == '0) && (r_cnt == '0);
  assign w_commit   = w_boundary && (r_pending || upd_req);

  // A request coincident with the boundary bypasses the shadow so it is not lost.
  always_comb begin
    w_val_nxt = r_val;
    w_dp_nxt  = r_dp;
    if (w_commit) begin
      w_val_nxt = upd_req ? val_in : r_shadow_val;
      w_dp_nxt  = upd_req ? dp_in  : r_shadow_dp;
    end
  end

  // w_zero_above[i] = digit i and every higher digit are zero.
  always_comb begin
    w_zero_above = '0;
    w_zero_above[DIGITS-1] = (w_val_nxt[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_zero_above[i] = w_zero_above[i+1] && (w_val_nxt[4*i +: 4] == 4'd0);
    end
  end

  // Outputs are computed from the next state so they register on the transition edge.
  always_comb begin
    w_digit     = 4'd0;
    w_dp_bit    = 1'b0;
    w_blank     = 1'b0;
    w_seg_nxt   = 8'hFF;
    w_dig_n_nxt = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == IdxW'(i)) begin
        w_digit  = w_val_nxt[4*i +: 4];
        w_dp_bit = w_dp_nxt[i];
        w_blank  = lz_en && (i != 0) && w_zero_above[i];
      end
    end
    if (w_state_nxt == StShow) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_idx_nxt == IdxW'(i)) w_dig_n_nxt[i] = 1'b0;
      end
      w_seg_nxt = {~w_dp_bit, (w_blank ? 7'h7F : decode7(w_digit))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StGuard;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_val        <= '0;
      r_dp         <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_ack        <= 1'b0;
      r_seg        <= 8'hFF;
      r_dig_n      <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
      r_dp    <= w_dp_nxt;
      if (upd_req) begin
        r_shadow_val <= val_in;
        r_shadow_dp  <= dp_in;
      end
      if (w_commit) begin
        r_pending <= 1'b0;
      end else if (upd_req) begin
        r_pending <= 1'b1;
      end
      r_ack   <= w_commit;
      r_seg   <= w_seg_nxt;
      r_dig_n <= w_dig_n_nxt;
    end
  end

  assign upd_ack = r_ack;
  assign seg     = r_seg;
  assign dig_n   = r_dig_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DWELL=4, GUARD=1 (20-cycle frame).
// Expected frames are pushed when an update is driven and popped when the ack arrives.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val_in;
  logic [3:0]  dp_in;
  logic        upd_req;
  logic        upd_ack;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  dig_n;

  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;
  bit mon_en  = 1'b0;

  // Expected segment bytes for one frame, {digit3, digit2, digit1, digit0}.
  logic [31:0] sb_q[$];

  seg_scan_ctrl #(
    .DIGITS (4),
    .DWELL  (4),
    .GUARD  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .val_in  (val_in),
    .dp_in   (dp_in),
    .upd_req (upd_req),
    .upd_ack (upd_ack),
    .lz_en   (lz_en),
    .seg     (seg),
    .dig_n   (dig_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs 1 time unit after each falling edge, after the stimulus process has sampled.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      check("onehot_dig", 32'($countones(~dig_n) <= 1), 32'd1);
      check("blank_when_off", 32'((dig_n != 4'hF) || (seg == 8'hFF)), 32'd1);
      if (upd_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic get_digit(input int d, output logic [7:0] s);
    logic [3:0] tgt;
    int n;
    tgt = 4'b1 << d;
    tgt = ~tgt;
    n = 0;
    while (dig_n !== tgt && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_digit%0d", d), 32'(dig_n), 32'(tgt));
    s = seg;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (upd_ack !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(upd_ack), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] exp;
    logic [7:0]  s;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        get_digit(d, s);
        check($sformatf("%s_d%0d", tag, d), 32'(s), 32'(exp[8*d +: 8]));
      end
    end
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] dp);
    val_in  = v;
    dp_in   = dp;
    upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    logic [3:0]  edig;
    logic [7:0]  eseg;
    logic [7:0]  s;

    rst     = 1'b1;
    val_in  = 16'h0000;
    dp_in   = 4'h0;
    upd_req = 1'b0;
    lz_en   = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_dig", 32'(dig_n), 32'hF);
    check("rst_ack", 32'(upd_ack), 32'd0);
    rst = 1'b0;

    // Idle frame: digits 0..3 for 4 cycles each, 1 guard cycle after each.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 5 == 4) begin
        edig = 4'hF;
        eseg = 8'hFF;
      end else begin
        edig = 4'b1 << (k / 5);
        edig = ~edig;
        eseg = (k / 5 == 0) ? 8'hC0 : 8'hFF;
      end
      check($sformatf("idle_dig_c%0d", k + 1), 32'(dig_n), 32'(edig));
      check($sformatf("idle_seg_c%0d", k + 1), 32'(seg), 32'(eseg));
    end
    check("idle_no_ack", 32'(ack_cnt), 32'd0);

    // Mid-frame update of 1234 with dp on digit 1.
    repeat (7) @(negedge clk);
    a0 = ack_cnt;
    sb_q.push_back({8'hF9, 8'hA4, 8'h30, 8'h99});
    strobe(16'h1234, 4'b0010);
    wait_ack("s2_ack");
    check_frame("s2_frame");
    check("s2_one_ack", 32'(ack_cnt - a0), 32'd1);

    // Leading-zero blanking on 0070, then disabled live.
    sb_q.push_back({8'hFF, 8'hFF, 8'hF8, 8'hC0});
    strobe(16'h0070, 4'b0000);
    wait_ack("s3_ack");
    check_frame("s3_lz_on");
    lz_en = 1'b0;
    sb_q.push_back({8'hC0, 8'hC0, 8'hF8, 8'hC0});
    check_frame("s3_lz_off");
    lz_en = 1'b1;

    // Three requests in one frame, last one on the boundary cycle.
    a0 = ack_cnt;
    get_digit(0, s);
    strobe(16'h1111, 4'b0000);
    get_digit(1, s);
    strobe(16'h2222, 4'b0000);
    get_digit(3, s);
    for (int n = 0; n < 10 && dig_n !== 4'hF; n++) @(negedge clk);
    check("s4_at_boundary", 32'(dig_n), 32'hF);
    check("s4_no_early_ack", 32'(ack_cnt - a0), 32'd0);
    sb_q.push_back({8'hB0, 8'hB0, 8'hB0, 8'hB0});
    strobe(16'h3333, 4'b0000);
    check("s4_ack_after_boundary", 32'(upd_ack), 32'd1);
    check_frame("s4_frame");
    check("s4_single_ack", 32'(ack_cnt - a0), 32'd1);

    // Code 0xC with dp -> 7F.
    sb_q.push_back({8'hFF, 8'hFF, 8'h7F, 8'h92});
    strobe(16'h00C5, 4'b0010);
    wait_ack("s5_ack");
    check_frame("s5_frame");

    // Reset mid-SHOW with a pending update.
    get_digit(0, s);
    get_digit(1, s);
    val_in  = 16'h8888;
    dp_in   = 4'hF;
    upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("s6_rst_seg", 32'(seg), 32'hFF);
    check("s6_rst_dig", 32'(dig_n), 32'hF);
    check("s6_rst_ack", 32'(upd_ack), 32'd0);
    rst = 1'b0;
    a0 = ack_cnt;
    sb_q.push_back({8'hFF, 8'hFF, 8'hFF, 8'hC0});
    check_frame("s6_frame");
    repeat (6) @(negedge clk);
    check("s6_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("s6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one 4-bit-to-8-segment digit decode path across DIGITS common-anode 7-segment digits.
- Sequences digit enables with a dead-time guard between digits, and snapshots display values from a requester through a frame-synchronous update handshake.
- Applies leading-zero blanking and per-digit decimal points.
- Sits between application logic (counters, clocks, status) and the board's segment/digit pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- DWELL, 50000, clk cycles each digit is lit.
- GUARD, 16, clk cycles of all-off dead time before each digit (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- val_in  in  4*DIGITS  packed BCD; digit i = val_in[4i+3:4i], digit 0 least significant.
- dp_in  in  DIGITS  decimal point request per digit, 1 = on.
- upd_req  in  1  1-cycle strobe: capture val_in/dp_in for display.
- upd_ack  out  1  1-cycle pulse: captured data became active.
- lz_en  in  1  1 = blank leading zeros; sampled live.
- seg  out  8  active-low segments; bit0..6 = a..g, bit7 = dp.
- dig_n  out  DIGITS  active-low digit enables, at most one low.

Behaviour:
- Reset (rst high at clk edge):
  - state GUARD; digit index 0; dwell/guard counter 0.
  - Active value 0, active dp 0, shadow value 0, shadow dp 0, pending 0.
  - Outputs: seg = 8'hFF, dig_n = all 1, upd_ack = 0.
  - Reset mid-frame aborts the scan; the pending update is discarded.
- State machine, two states:
  - GUARD: dig_n all 1, seg 8'hFF, for GUARD cycles, then SHOW with the same index.
  - SHOW: dig_n[idx] = 0, seg = decode(idx), for DWELL cycles, then GUARD with idx+1.
  - idx wraps from DIGITS-1 to 0.
- Frame = DIGITS*(GUARD+DWELL) cycles. Frame boundary = cycle of entry to GUARD with idx 0, including the first cycle after reset release.
- All outputs are registered: seg/dig_n change on the same edge as the state transition, with no combinational path from inputs.
- Decode, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, bit7=1).
  - Codes 10..15 produce 7F/FF pattern: segments a..g all off (bits 6:0 = 1).
  - bit7 = ~dp of that digit, independent of blanking.
- Leading-zero blanking: with lz_en=1, digit i (i≥1) is blanked (bits 6:0 = 1) when digit i and all higher digits are 0. Digit 0 is never blanked.
- Update handshake:
  - Any cycle with upd_req=1 loads the shadow registers and sets pending. Latest request wins.
  - At the frame boundary cycle, if pending or upd_req is high:
    - Active value/dp load from val_in/dp_in if upd_req is high this cycle, else from the shadow.
    - pending clears.
    - upd_ack pulses high for exactly that one cycle.
  - Active value is never changed mid-frame, so there is no tearing.
  - Multiple requests within one frame produce one ack.
  - upd_req on the cycle after a boundary waits a full frame.
- Counters: width = clog2(max(DWELL,GUARD)+1). No overflow; terminal count compares against DWELL-1 / GUARD-1.

Test Plan:
- Use DIGITS=4, DWELL=4, GUARD=1 (frame = 20 cycles) throughout.
- Reset release, no updates, lz_en=1 -> dig_n cycles E,D,B,7 (4 cycles each, F for 1 cycle between). seg = FF on digits 1..3 and C0 on digit 0. upd_ack never high.
- upd_req with val_in=16'h1234, dp_in=4'b0010, mid-frame -> upd_ack pulses once at the next frame boundary. Next frame shows digit0=99, digit1=30 (B0 with dp), digit2=A4, digit3=F9.
- val_in=16'h0070, lz_en=1 then lz_en=0 -> lz_en=1: digit3/digit2 FF, digit1 F8, digit0 C0. lz_en=0: digit3/digit2 C0.
- Three upd_req strobes (0x1111, 0x2222, 0x3333) in one frame, the last coincident with the boundary -> single upd_ack, and the displayed value is 0x3333.
- val_in digit of 4'hC with dp set -> seg=7F for that digit. Assert rst for one cycle mid-SHOW with an update pending -> next cycle seg=FF, dig_n=F, no upd_ack, and the display returns to 0.
- Throughout all scenarios, check that dig_n never has more than one bit low and that seg=FF whenever dig_n=F.
